// File: rtl/watch_pkg.sv
// Shared button indices and repeat-state encoding for the watch control path.
package watch_pkg;

    localparam int BTN_MODE  = 0;
    localparam int BTN_SET   = 1;
    localparam int BTN_INC   = 2;
    localparam int BTN_DEC   = 3;
    localparam int BTN_LIGHT = 4;
    localparam int NUM_BTN   = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: 2-flop synchronizer, run-length debounce, registered rising-edge pulse.
// Latency: level/pulse DEBOUNCE_CYCLES+2 edges after the pad changes; no backpressure.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press_p,
    output logic fall_d
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       d_q, d_d;
    logic [7:0] cnt_q, cnt_d;
    logic       press_q, press_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        d_d     = d_q;
        cnt_d   = 8'd0;
        press_d = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q != d_q) begin
            // The sample that would bring the run to DEBOUNCE_CYCLES commits the new level.
            if (cnt_q >= CNT_LAST) begin
                d_d     = sync2_q;
                press_d = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            d_q     <= 1'b0;
            cnt_q   <= 8'd0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign level   = d_q;
    assign press_p = press_q;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions the five watch pushbuttons into debounced levels and one-cycle press pulses;
// BTN_AUTOREPEAT_EN adds inc/dec auto-repeat. Pulse latency DEBOUNCE_CYCLES+2 edges; no backpressure.
module btn_conditioner
    import watch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int REPEAT_DELAY    = 512,
    parameter int REPEAT_PERIOD   = 128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_set,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_light,
    output logic       mode_p,
    output logic       set_p,
    output logic       inc_p,
    output logic       dec_p,
    output logic       light_p,
    output logic [4:0] btn_level
);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] fall;
    logic [1:0]         rpt;

    assign raw = {btn_light, btn_dec, btn_inc, btn_set, btn_mode};

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset  (reset),
            .btn_raw(raw[g]),
            .level  (level[g]),
            .press_p(press[g]),
            .fall_d (fall[g])
        );
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RCNT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [RCNT_W-1:0] RC_ONE    = RCNT_W'(1);
    localparam logic [RCNT_W-1:0] RC_DELAY  = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] RC_PERIOD = RCNT_W'(REPEAT_PERIOD);

    logic conflict;
    assign conflict = level[BTN_INC] & level[BTN_DEC];

    for (genvar r = 0; r < 2; r++) begin : g_rpt
        localparam int B = BTN_INC + r;

        rpt_state_t        state_q;
        logic [RCNT_W-1:0] rcnt_q;
        logic              rpt_q;

        // The press pulse is seen one edge late, so DELAY is loaded one short.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= IDLE;
                rcnt_q  <= '0;
                rpt_q   <= 1'b0;
            end else begin
                rpt_q <= 1'b0;
                if (conflict || fall[B]) begin
                    state_q <= IDLE;
                    rcnt_q  <= '0;
                end else begin
                    case (state_q)
                        IDLE: begin
                            if (press[B]) begin
                                state_q <= DELAY;
                                rcnt_q  <= RC_DELAY;
                            end
                        end
                        DELAY, REPEAT: begin
                            if (rcnt_q <= RC_ONE) begin
                                state_q <= REPEAT;
                                rpt_q   <= 1'b1;
                                rcnt_q  <= RC_PERIOD;
                            end else begin
                                rcnt_q <= rcnt_q - RC_ONE;
                            end
                        end
                        default: begin
                            state_q <= IDLE;
                            rcnt_q  <= '0;
                        end
                    endcase
                end
            end
        end

        assign rpt[r] = rpt_q;
    end
`else
    logic unused_rpt;
    assign unused_rpt = ^{fall, 32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
    assign rpt        = 2'b00;
`endif

    assign mode_p    = press[BTN_MODE];
    assign set_p     = press[BTN_SET];
    assign inc_p     = press[BTN_INC] | rpt[0];
    assign dec_p     = press[BTN_DEC] | rpt[1];
    assign light_p   = press[BTN_LIGHT];
    assign btn_level = level;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: two instances (debounce 2 and 3) on shared pads, checked every cycle
// against a window/offset model, plus literal pulse-timing expectations per scenario.
module tb_btn_conditioner;

    localparam int RD = 8;
    localparam int RP = 4;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif
    localparam int N_RPT = AR ? 7 : 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] r;
    wire  [4:0] p0, lv0, p1, lv1;

    always #5 clk = ~clk;

    btn_conditioner #(.DEBOUNCE_CYCLES(2), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clk(clk), .reset(reset),
        .btn_mode(r[0]), .btn_set(r[1]), .btn_inc(r[2]), .btn_dec(r[3]), .btn_light(r[4]),
        .mode_p(p0[0]), .set_p(p0[1]), .inc_p(p0[2]), .dec_p(p0[3]), .light_p(p0[4]),
        .btn_level(lv0)
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(3), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut3 (
        .clk(clk), .reset(reset),
        .btn_mode(r[0]), .btn_set(r[1]), .btn_inc(r[2]), .btn_dec(r[3]), .btn_light(r[4]),
        .mode_p(p1[0]), .set_p(p1[1]), .inc_p(p1[2]), .dec_p(p1[3]), .light_p(p1[4]),
        .btn_level(lv1)
    );

    int errs = 0;
    int nchk = 0;

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Edge bookkeeping: values sampled by the DUT at each rising edge.
    int         edge_n = 0;
    logic [4:0] samp_raw = 5'd0;
    logic       samp_rst = 1'b1;
    always @(posedge clk) begin
        samp_raw <= r;
        samp_rst <= reset;
        edge_n   <= edge_n + 1;
    end

    logic [4:0] hist [0:4095];
    int         last_rst = 0;
    logic [4:0] lvl_m [2];
    bit         alive [2][2];
    int         pcyc  [2][2];

    int         pul_q [10][$];
    int         lvl_fall [10];
    int         lvl_rise [10];
    logic [4:0] prev_l [2];

    // Synchronized sample used by the debouncer at edge x: pad value two edges earlier.
    function automatic logic s_at(input int x, input int b);
        if (x - 2 >= 1) return hist[x-2][b];
        return 1'b0;
    endfunction

    task automatic model_step(input int e);
        logic [4:0] exp_l, exp_p, press_v, fall_v, act_p, act_l;
        bit flip, conflict;
        int dc, b;
        hist[e] = samp_rst ? 5'd0 : samp_raw;
        if (samp_rst) last_rst = e;
        for (int i = 0; i < 2; i++) begin
            dc       = (i == 0) ? 2 : 3;
            conflict = lvl_m[i][2] & lvl_m[i][3];
            for (int bb = 0; bb < 5; bb++) begin
                flip = !samp_rst;
                for (int j = 0; j < dc; j++) begin
                    if (e - j <= last_rst) flip = 1'b0;
                    else if (s_at(e - j, bb) == lvl_m[i][bb]) flip = 1'b0;
                end
                press_v[bb] = flip & !lvl_m[i][bb];
                fall_v[bb]  = flip & lvl_m[i][bb];
                exp_l[bb]   = samp_rst ? 1'b0 : (lvl_m[i][bb] ^ flip);
            end
            exp_p = press_v;
            for (int rr = 0; rr < 2; rr++) begin
                b = 2 + rr;
                if (samp_rst || conflict || fall_v[b]) alive[i][rr] = 1'b0;
                else if (alive[i][rr] && (e - pcyc[i][rr]) >= RD &&
                         ((e - pcyc[i][rr] - RD) % RP) == 0) exp_p[b] = 1'b1;
                if (press_v[b]) begin
                    alive[i][rr] = AR;
                    pcyc[i][rr]  = e;
                end
            end
            lvl_m[i] = exp_l;
            act_p = (i == 0) ? p0 : p1;
            act_l = (i == 0) ? lv0 : lv1;
            chk((i == 0) ? "pulses_dc2" : "pulses_dc3", int'(act_p), int'(exp_p));
            chk((i == 0) ? "level_dc2" : "level_dc3", int'(act_l), int'(exp_l));
            for (int bb = 0; bb < 5; bb++) begin
                if (act_p[bb]) pul_q[i*5+bb].push_back(e);
                if (prev_l[i][bb] && !act_l[bb]) lvl_fall[i*5+bb] = e;
                if (!prev_l[i][bb] && act_l[bb]) lvl_rise[i*5+bb]++;
            end
            prev_l[i] = act_l;
        end
    endtask

    always @(negedge clk) begin
        if (edge_n >= 1) model_step(edge_n);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_rec();
        for (int q = 0; q < 10; q++) begin
            pul_q[q].delete();
            lvl_fall[q] = -1;
            lvl_rise[q] = 0;
        end
    endtask

    function automatic int first_pulse(input int q);
        if (pul_q[q].size() > 0) return pul_q[q][0];
        return -1;
    endfunction

    int k, e0;
    int exp_off [7] = '{0, 8, 12, 16, 20, 24, 28};

    initial begin
        for (int i = 0; i < 2; i++) begin
            lvl_m[i] = 5'd0;
            prev_l[i] = 5'd0;
            for (int rr = 0; rr < 2; rr++) begin
                alive[i][rr] = 1'b0;
                pcyc[i][rr]  = 0;
            end
        end
        clear_rec();
        reset = 1'b1;
        r     = 5'd0;
        tick(3);
        chk("reset_outputs", int'({p0, lv0, p1, lv1}), 0);
        reset = 1'b0;
        tick(5);

        // Single 2-cycle press of set.
        clear_rec();
        k = edge_n + 1;
        r = 5'b00010;
        tick(2);
        r = 5'b00000;
        tick(12);
        chk("set_p_count", pul_q[1].size(), 1);
        chk("set_p_edge", first_pulse(1), k + 3);
        chk("set_level_fall", lvl_fall[1], k + 5);
        chk("set_dc3_no_pulse", pul_q[6].size(), 0);

        // Two-cycle glitch on mode: rejected by debounce 3, accepted by debounce 2.
        clear_rec();
        k = edge_n + 1;
        r = 5'b00001;
        tick(2);
        r = 5'b00000;
        tick(10);
        chk("glitch_dc3_pulses", pul_q[5].size(), 0);
        chk("glitch_dc3_level", lvl_rise[5], 0);
        chk("glitch_dc2_pulse", first_pulse(0), k + 3);
        clear_rec();
        k = edge_n + 1;
        r = 5'b00001;
        tick(3);
        r = 5'b00000;
        tick(10);
        chk("hold3_dc3_count", pul_q[5].size(), 1);
        chk("hold3_dc3_edge", first_pulse(5), k + 4);

        // Inc held 30 cycles: press then repeats at fixed offsets.
        clear_rec();
        k = edge_n + 1;
        r = 5'b00100;
        tick(30);
        r = 5'b00000;
        tick(20);
        chk("autorep_count", pul_q[2].size(), N_RPT);
        for (int j = 0; j < N_RPT; j++)
            if (j < pul_q[2].size()) chk("autorep_offset", pul_q[2][j] - (k + 3), exp_off[j]);
        chk("autorep_dc3_first", first_pulse(7), k + 4);
        chk("autorep_no_dec", pul_q[3].size(), 0);

        // Inc then dec one cycle later, both held: no repeats.
        clear_rec();
        k = edge_n + 1;
        r = 5'b00100;
        tick(1);
        r = 5'b01100;
        tick(29);
        r = 5'b01000;
        tick(1);
        r = 5'b00000;
        tick(20);
        chk("conflict_inc_count", pul_q[2].size(), 1);
        chk("conflict_dec_count", pul_q[3].size(), 1);
        chk("conflict_inc_edge", first_pulse(2), k + 3);
        chk("conflict_dec_edge", first_pulse(3), k + 4);

        // All five together.
        clear_rec();
        k = edge_n + 1;
        r = 5'b11111;
        tick(5);
        r = 5'b00000;
        tick(10);
        for (int b = 0; b < 5; b++) begin
            chk("simul_count", pul_q[b].size(), 1);
            chk("simul_edge", first_pulse(b), k + 3);
        end

        // Reset while light is held: re-fires as a fresh press.
        r = 5'b10000;
        tick(10);
        reset = 1'b1;
        tick(1);
        chk("mid_reset_outputs", int'({p0, lv0, p1, lv1}), 0);
        tick(2);
        reset = 1'b0;
        clear_rec();
        e0 = edge_n + 1;
        tick(10);
        chk("rst_light_count", pul_q[4].size(), 1);
        chk("rst_light_edge", first_pulse(4), e0 + 3);
        chk("rst_light_dc3_edge", first_pulse(9), e0 + 4);
        r = 5'b00000;
        tick(10);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Front-end input conditioner for the watch chip's five raw pushbuttons (mode, set, inc, dec, light). Synchronizes each pad input and debounces it. Emits exactly one single-cycle press pulse per accepted press. Generates auto-repeat pulses on inc/dec while they are held. Sits between the `soc_top` button pads and the mode/set/stopwatch control FSMs, which consume only the conditioned pulses.

## Interface
- `DEBOUNCE_CYCLES`, default 2: consecutive samples needed to accept a level change. Range 1..255.
- `REPEAT_DELAY`, default 512: hold cycles from the press pulse to the first repeat pulse. Must be ≥ 2.
- `REPEAT_PERIOD`, default 128: cycles between repeat pulses. Must be ≥ 1.
- `clk` in 1: system clock. Single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `btn_mode`, `btn_set`, `btn_inc`, `btn_dec`, `btn_light` in 1 each: raw, asynchronous, active-high pad inputs.
- `mode_p`, `set_p`, `inc_p`, `dec_p`, `light_p` out 1 each: registered single-cycle press pulses. `inc_p`/`dec_p` also carry repeat pulses.
- `btn_level` out 5: debounced levels. Bit order `{light, dec, inc, set, mode}`.

## Operation
- Each button has its own 2-flop synchronizer, giving synchronized level `s`.
- Debounce:
  - Each button holds a debounced level `d` and a counter `cnt`.
  - Each edge where `s != d`: `cnt` increments.
  - Each edge where `s == d`: `cnt` clears.
  - When `cnt` would reach `DEBOUNCE_CYCLES`: `d` takes `s` and `cnt` clears.
- Press pulse: asserted for one cycle on the edge where `d` goes 0→1. A 1→0 transition produces no pulse.
- Repeat FSM, per inc and dec. States are IDLE, DELAY, REPEAT.
  - IDLE→DELAY: on the press pulse; load `rcnt`.
  - DELAY→REPEAT: after `REPEAT_DELAY` cycles counted from the press-pulse cycle; emit a pulse.
  - REPEAT: emits one pulse every `REPEAT_PERIOD` cycles.
  - Any state→IDLE: in the same edge that `d` falls.
- Conflict rule: while both inc and dec are debounced-high, both repeat FSMs hold in IDLE and no repeats are emitted. Their initial press pulses are still emitted normally.
- Buttons are independent. Any subset may pulse in the same cycle.
- Counters saturate and never wrap. `rcnt` width is `$clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1)`.
- Reset:
  - Clears synchronizers, `d`, `cnt`, all repeat FSMs, and all outputs to 0.
  - A button still held through reset deassertion is treated as a new press. It pulses after normal latency.

## Timing
- Let edge k be the first edge that samples a raw input high, with the input held stable afterward.
- `d` rises and the press pulse is high in the cycle following edge k+1+`DEBOUNCE_CYCLES`. For default 2, that is 4 edges after the input goes high.
- Minimum accepted press width: `DEBOUNCE_CYCLES` clock periods. Default 2 = 20 ns at a 10 ns clock.
- The first repeat pulse occurs exactly `REPEAT_DELAY` cycles after the press pulse. Each later pulse follows `REPEAT_PERIOD` cycles after the previous one.
- Release latency: `d` falls `DEBOUNCE_CYCLES`+1 edges after raw goes low. The repeat FSM returns to IDLE on that same edge; no pulse is issued on that edge.
- A glitch shorter than `DEBOUNCE_CYCLES` samples produces no `d` change and no pulse.

## Configuration
- `BTN_AUTOREPEAT_EN`
  - Defined: the repeat FSMs and `rcnt` are compiled in as described above.
  - Undefined: the FSMs are removed. `inc_p`/`dec_p` carry press pulses only, and `REPEAT_DELAY`/`REPEAT_PERIOD` are ignored.

## Structure
- Shared package `watch_pkg`:
  - Button index constants `BTN_MODE=0`, `BTN_SET=1`, `BTN_INC=2`, `BTN_DEC=3`, `BTN_LIGHT=4`, and `NUM_BTN=5`.
  - Repeat state enum `rpt_state_t` {IDLE, DELAY, REPEAT}.
- Sub-module `btn_debounce`:
  - Contents: synchronizer, debounce counter, `d`, and press-pulse register.
  - Parameterized by `DEBOUNCE_CYCLES`.
  - Instantiated 5× via generate.
- The repeat logic lives in the top module.

## Test plan
- **Single press**, defaults: `btn_set` high 2 cycles then low → `set_p` high for exactly 1 cycle, 4 edges after the rise; `btn_level[1]` falls 3 edges after release.
- **Glitch reject**, `DEBOUNCE_CYCLES`=3: `btn_mode` high 2 cycles → no `mode_p` and `btn_level[0]` stays 0. Then hold 3 cycles → one pulse.
- **Auto-repeat**, `REPEAT_DELAY`=8, `REPEAT_PERIOD`=4: hold `btn_inc` 30 cycles → `inc_p` pulses at offsets 0, 8, 12, 16, 20, 24, 28 from the press pulse. Release → no further pulses.
- **Conflict**: hold inc, and hold dec starting 1 cycle later, both for 30 cycles → exactly one `inc_p` and one `dec_p`, no repeats.
- **Simultaneous**: all five buttons rise on the same edge → all five pulses in the same cycle, each 1 cycle wide.
- **Reset mid-hold**: `btn_light` held, `reset` asserted 3 cycles then released with the button still held → all outputs 0 during reset; `light_p` re-fires 4 edges after reset deassertion. Repeat with `BTN_AUTOREPEAT_EN` undefined: held inc gives a single pulse only.
